// File: rtl/llc_req_arbiter_if.sv
// llc_req_arbiter_if: request/LLC bus bundle for the LLC front-end arbiter
// Signals: cpu/snp/mnt valid-op(-addr)-ready request channels, llc_op/llc_addr/llc_hold
// LLC side, busy/illegal_op status and stat_cpu/stat_snp/stat_hold counters.
// Modports: slave = arbiter side, master = agents/LLC side.
interface llc_req_arbiter_if #(
    parameter int STAT_W = 16
);
    logic              cpu_valid;
    logic [3:0]        cpu_op;
    logic [31:0]       cpu_addr;
    logic              cpu_ready;
    logic              snp_valid;
    logic [3:0]        snp_op;
    logic [31:0]       snp_addr;
    logic              snp_ready;
    logic              mnt_valid;
    logic [3:0]        mnt_op;
    logic              mnt_ready;
    logic [3:0]        llc_op;
    logic [31:0]       llc_addr;
    logic              llc_hold;
    logic              busy;
    logic              illegal_op;
    logic [STAT_W-1:0] stat_cpu;
    logic [STAT_W-1:0] stat_snp;
    logic [STAT_W-1:0] stat_hold;

    modport slave (
        input  cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr,
               mnt_valid, mnt_op, llc_hold,
        output cpu_ready, snp_ready, mnt_ready, llc_op, llc_addr, busy,
               illegal_op, stat_cpu, stat_snp, stat_hold
    );

    modport master (
        output cpu_valid, cpu_op, cpu_addr, snp_valid, snp_op, snp_addr,
               mnt_valid, mnt_op, llc_hold,
        input  cpu_ready, snp_ready, mnt_ready, llc_op, llc_addr, busy,
               illegal_op, stat_cpu, stat_snp, stat_hold
    );
endinterface

// File: rtl/llc_req_arbiter.sv
// llc_req_arbiter: merges CPU, snoop and maintenance requests into one LLC op/addr stream
// Ports: clk, rst_n (async active-low), bus (llc_req_arbiter_if.slave):
//   request channels in, combinational readies out, registered llc_op/llc_addr,
//   llc_hold in, busy/illegal_op status, stat_* counters.
// Optional: define LLC_ARB_STATS_EN to build the saturating statistics counters;
//   otherwise the stat ports are tied to zero.
module llc_req_arbiter #(
    parameter logic [3:0] IDLE_OP        = 4'd8,
    parameter int         MAX_SNP_STREAK = 4,
    parameter int         STAT_W         = 16
) (
    input logic                clk,
    input logic                rst_n,
    llc_req_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_SNP_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     addr_q, addr_d;
    logic            ill_q, ill_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            acc, force_cpu, gnt_mnt, gnt_snp, gnt_cpu;
    logic            ok_mnt, ok_snp, ok_cpu, issue;
    logic [3:0]      nxt_op;
    logic [31:0]     nxt_addr;

    always_comb begin
        acc       = (state_q == IDLE) || (state_q == ISSUE && !bus.llc_hold) || (state_q == HOLD);
        // a CPU request starved by MAX_SNP_STREAK snoop grants overrides snoop priority
        force_cpu = bus.cpu_valid && (streak_q == SW'(MAX_SNP_STREAK));
        gnt_mnt   = acc && bus.mnt_valid;
        gnt_snp   = acc && !bus.mnt_valid && bus.snp_valid && !force_cpu;
        gnt_cpu   = acc && !bus.mnt_valid && bus.cpu_valid && (!bus.snp_valid || force_cpu);
        ok_mnt    = gnt_mnt && (bus.mnt_op == 4'd8 || bus.mnt_op == 4'd9);
        ok_snp    = gnt_snp && bus.snp_op >= 4'd3 && bus.snp_op <= 4'd6;
        ok_cpu    = gnt_cpu && bus.cpu_op <= 4'd2;
        issue     = ok_mnt || ok_snp || ok_cpu;
        nxt_op    = ok_mnt ? bus.mnt_op : ok_snp ? bus.snp_op : bus.cpu_op;
        nxt_addr  = ok_mnt ? 32'd0 : ok_snp ? bus.snp_addr : bus.cpu_addr;
        state_d   = (state_q == ISSUE && bus.llc_hold) ? HOLD : issue ? ISSUE : IDLE;
        // outside the accept window the current op is being held on the LLC
        op_d      = !acc ? op_q : issue ? nxt_op : IDLE_OP;
        addr_d    = issue ? nxt_addr : addr_q;
        // accepted but out of range: consumed without issue
        ill_d     = (gnt_mnt || gnt_snp || gnt_cpu) && !issue;
        streak_d  = (!bus.cpu_valid || ok_cpu) ? '0 :
                    (ok_snp && streak_q != SW'(MAX_SNP_STREAK)) ? streak_q + SW'(1) : streak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= IDLE_OP;
            addr_q   <= '0;
            ill_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            ill_q    <= ill_d;
            streak_q <= streak_d;
        end
    end

    assign bus.cpu_ready  = gnt_cpu;
    assign bus.snp_ready  = gnt_snp;
    assign bus.mnt_ready  = gnt_mnt;
    assign bus.llc_op     = op_q;
    assign bus.llc_addr   = addr_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.illegal_op = ill_q;

`ifdef LLC_ARB_STATS_EN
    logic [STAT_W-1:0] scpu_q, scpu_d, ssnp_q, ssnp_d, shold_q, shold_d;

    always_comb begin
        scpu_d  = scpu_q + STAT_W'(ok_cpu && !(&scpu_q));
        ssnp_d  = ssnp_q + STAT_W'(ok_snp && !(&ssnp_q));
        shold_d = shold_q + STAT_W'(state_q == HOLD && !(&shold_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scpu_q  <= '0;
            ssnp_q  <= '0;
            shold_q <= '0;
        end else begin
            scpu_q  <= scpu_d;
            ssnp_q  <= ssnp_d;
            shold_q <= shold_d;
        end
    end

    assign bus.stat_cpu  = scpu_q;
    assign bus.stat_snp  = ssnp_q;
    assign bus.stat_hold = shold_q;
`else
    assign bus.stat_cpu  = {STAT_W{1'b0}};
    assign bus.stat_snp  = {STAT_W{1'b0}};
    assign bus.stat_hold = {STAT_W{1'b0}};
`endif
endmodule

// File: tb/tb_llc_req_arbiter.sv
// tb_llc_req_arbiter: self-checking scenario bench for llc_req_arbiter with an issue scoreboard
// Ports: none; drives the arbiter through an llc_req_arbiter_if instance.
module tb_llc_req_arbiter;
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_cpu;
    int   exp_snp;
    int   exp_hold;
    exp_t exp_q[$];
    exp_t e;

    llc_req_arbiter_if #(.STAT_W(16)) bus ();

    llc_req_arbiter #(.IDLE_OP(4'd8), .MAX_SNP_STREAK(4), .STAT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cpu_valid = 0; bus.cpu_op = 0; bus.cpu_addr = 0;
        bus.snp_valid = 0; bus.snp_op = 0; bus.snp_addr = 0;
        bus.mnt_valid = 0; bus.mnt_op = 0; bus.llc_hold = 0;
        #12;
        checks++;
        if (bus.llc_op !== 4'd8 || bus.llc_addr !== 32'd0) begin
            errors++; $display("FAIL reset_llc got %h/%h exp 8/0", bus.llc_op, bus.llc_addr);
        end
        checks++;
        if ({bus.busy, bus.illegal_op, bus.cpu_ready, bus.snp_ready, bus.mnt_ready} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000",
                {bus.busy, bus.illegal_op, bus.cpu_ready, bus.snp_ready, bus.mnt_ready});
        end
        checks++;
        if ({bus.stat_cpu, bus.stat_snp, bus.stat_hold} !== 48'd0) begin
            errors++; $display("FAIL reset_stats got %h exp 0", {bus.stat_cpu, bus.stat_snp, bus.stat_hold});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cpu();
        bus.cpu_valid = 1; bus.cpu_op = 4'd0; bus.cpu_addr = 32'h1000_0040;
        exp_q.push_back('{op: 4'd0, addr: 32'h1000_0040}); exp_cpu++;
        @(negedge clk);
        checks++;
        if ({bus.cpu_ready, bus.snp_ready, bus.mnt_ready} !== 3'b100) begin
            errors++; $display("FAIL single_ready got %b exp 100", {bus.cpu_ready, bus.snp_ready, bus.mnt_ready});
        end
        tick();
        bus.cpu_valid = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr || bus.busy !== 1'b1) begin
            errors++; $display("FAIL single_issue got %h/%h/%b exp %h/%h/1", bus.llc_op, bus.llc_addr, bus.busy, e.op, e.addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.llc_op !== 4'd8 || bus.llc_addr !== 32'h1000_0040 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_idle got %h/%h/%b exp 8/10000040/0", bus.llc_op, bus.llc_addr, bus.busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.cpu_valid = 1; bus.cpu_op = 4'd1; bus.cpu_addr = 32'hA;
        exp_q.push_back('{op: 4'd1, addr: 32'hA}); exp_cpu++;
        @(negedge clk);
        checks++;
        if (bus.cpu_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready0 got %b exp 1", bus.cpu_ready);
        end
        tick();
        bus.cpu_op = 4'd2; bus.cpu_addr = 32'hB;
        exp_q.push_back('{op: 4'd2, addr: 32'hB}); exp_cpu++;
        @(negedge clk);
        checks++;
        if (bus.cpu_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready1 got %b exp 1", bus.cpu_ready);
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr || bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_first got %h/%h/%b exp %h/%h/1", bus.llc_op, bus.llc_addr, bus.busy, e.op, e.addr);
        end
        tick();
        bus.cpu_valid = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr || bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_second got %h/%h/%b exp %h/%h/1", bus.llc_op, bus.llc_addr, bus.busy, e.op, e.addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.llc_op !== 4'd8 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got %h/%b exp 8/0", bus.llc_op, bus.busy);
        end
        tick();
    endtask

    task automatic test_hold();
        exp_t held;
        bus.cpu_valid = 1; bus.cpu_op = 4'd1; bus.cpu_addr = 32'hC0;
        exp_q.push_back('{op: 4'd1, addr: 32'hC0}); exp_cpu++;
        @(negedge clk);
        tick();
        bus.llc_hold = 1; bus.cpu_op = 4'd2; bus.cpu_addr = 32'hD0;
        @(negedge clk);
        held = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== held.op || bus.llc_addr !== held.addr || bus.busy !== 1'b1) begin
            errors++; $display("FAIL hold_issue got %h/%h/%b exp %h/%h/1", bus.llc_op, bus.llc_addr, bus.busy, held.op, held.addr);
        end
        checks++;
        if (bus.cpu_ready !== 1'b0) begin
            errors++; $display("FAIL hold_no_accept got %b exp 0", bus.cpu_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.llc_op !== held.op || bus.llc_addr !== held.addr || bus.busy !== 1'b1) begin
            errors++; $display("FAIL hold_stable got %h/%h/%b exp %h/%h/1", bus.llc_op, bus.llc_addr, bus.busy, held.op, held.addr);
        end
        checks++;
        if (bus.cpu_ready !== 1'b1) begin
            errors++; $display("FAIL hold_accept got %b exp 1", bus.cpu_ready);
        end
        exp_q.push_back('{op: 4'd2, addr: 32'hD0}); exp_cpu++; exp_hold++;
        tick();
        bus.cpu_valid = 0; bus.llc_hold = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr) begin
            errors++; $display("FAIL hold_next got %h/%h exp %h/%h", bus.llc_op, bus.llc_addr, e.op, e.addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.llc_op !== 4'd8 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle got %h/%b exp 8/0", bus.llc_op, bus.busy);
        end
        tick();
    endtask

    task automatic test_streak();
        logic [9:0] cpu_turn;
        int sn;
        int cn;
        cpu_turn = 10'b10000_10000;
        sn = 0; cn = 0;
        bus.cpu_valid = 1; bus.snp_valid = 1;
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) begin
                bus.cpu_valid = 0; bus.snp_valid = 0;
            end else begin
                bus.snp_op = 4'(3 + sn % 4); bus.snp_addr = 32'h5000 + 32'(sn);
                bus.cpu_op = 4'(cn % 3);    bus.cpu_addr = 32'hC000 + 32'(cn);
                if (cpu_turn[i]) begin
                    exp_q.push_back('{op: bus.cpu_op, addr: bus.cpu_addr}); exp_cpu++;
                end else begin
                    exp_q.push_back('{op: bus.snp_op, addr: bus.snp_addr}); exp_snp++;
                end
            end
            @(negedge clk);
            if (i < 10) begin
                checks++;
                if ({bus.cpu_ready, bus.snp_ready} !== {cpu_turn[i], !cpu_turn[i]}) begin
                    errors++; $display("FAIL streak_grant%0d got %b exp %b", i,
                        {bus.cpu_ready, bus.snp_ready}, {cpu_turn[i], !cpu_turn[i]});
                end
            end
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.llc_op !== e.op || bus.llc_addr !== e.addr) begin
                    errors++; $display("FAIL streak_issue%0d got %h/%h exp %h/%h", i, bus.llc_op, bus.llc_addr, e.op, e.addr);
                end
            end
            tick();
            if (i < 10) begin
                if (cpu_turn[i]) cn++;
                else sn++;
            end
        end
    endtask

    task automatic test_mnt_priority();
        bus.mnt_valid = 1; bus.mnt_op = 4'd9;
        bus.snp_valid = 1; bus.snp_op = 4'd4; bus.snp_addr = 32'h77;
        bus.cpu_valid = 1; bus.cpu_op = 4'd1; bus.cpu_addr = 32'h88;
        exp_q.push_back('{op: 4'd9, addr: 32'd0});
        @(negedge clk);
        checks++;
        if ({bus.cpu_ready, bus.snp_ready, bus.mnt_ready} !== 3'b001) begin
            errors++; $display("FAIL mnt_ready got %b exp 001", {bus.cpu_ready, bus.snp_ready, bus.mnt_ready});
        end
        tick();
        bus.mnt_valid = 0; bus.snp_valid = 0; bus.cpu_valid = 0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr) begin
            errors++; $display("FAIL mnt_issue got %h/%h exp %h/%h", bus.llc_op, bus.llc_addr, e.op, e.addr);
        end
        tick();
        tick();
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                bus.cpu_valid = 1; bus.cpu_op = 4'd5; bus.cpu_addr = 32'hBAD;
            end else begin
                bus.mnt_valid = 1; bus.mnt_op = 4'd7;
            end
            @(negedge clk);
            checks++;
            if ((k == 0 ? bus.cpu_ready : bus.mnt_ready) !== 1'b1 || bus.illegal_op !== 1'b0) begin
                errors++; $display("FAIL illegal_accept%0d got %b/%b exp 1/0", k,
                    (k == 0 ? bus.cpu_ready : bus.mnt_ready), bus.illegal_op);
            end
            tick();
            bus.cpu_valid = 0; bus.mnt_valid = 0;
            @(negedge clk);
            checks++;
            if (bus.illegal_op !== 1'b1 || bus.llc_op !== 4'd8 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL illegal_pulse%0d got %b/%h/%b exp 1/8/0", k, bus.illegal_op, bus.llc_op, bus.busy);
            end
            tick();
            @(negedge clk);
            checks++;
            if (bus.illegal_op !== 1'b0) begin
                errors++; $display("FAIL illegal_clear%0d got %b exp 0", k, bus.illegal_op);
            end
            tick();
        end
    endtask

    task automatic test_stats();
        logic [15:0] ec, es, eh;
`ifdef LLC_ARB_STATS_EN
        ec = 16'(exp_cpu); es = 16'(exp_snp); eh = 16'(exp_hold);
`else
        ec = 16'd0; es = 16'd0; eh = 16'd0;
`endif
        @(negedge clk);
        checks++;
        if (bus.stat_cpu !== ec || bus.stat_snp !== es || bus.stat_hold !== eh) begin
            errors++; $display("FAIL stats got %0d/%0d/%0d exp %0d/%0d/%0d",
                bus.stat_cpu, bus.stat_snp, bus.stat_hold, ec, es, eh);
        end
        tick();
    endtask

    task automatic test_reset_in_hold();
        bus.cpu_valid = 1; bus.cpu_op = 4'd2; bus.cpu_addr = 32'hE0;
        exp_q.push_back('{op: 4'd2, addr: 32'hE0});
        @(negedge clk);
        tick();
        bus.cpu_valid = 0; bus.llc_hold = 1;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (bus.llc_op !== e.op || bus.llc_addr !== e.addr) begin
            errors++; $display("FAIL rst_hold_issue got %h/%h exp %h/%h", bus.llc_op, bus.llc_addr, e.op, e.addr);
        end
        tick();
        bus.llc_hold = 0;
        #2;
        checks++;
        if (bus.busy !== 1'b1 || bus.llc_op !== 4'd2) begin
            errors++; $display("FAIL rst_hold_pre got %b/%h exp 1/2", bus.busy, bus.llc_op);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.llc_op !== 4'd8 || bus.busy !== 1'b0 || bus.llc_addr !== 32'd0) begin
            errors++; $display("FAIL rst_async got %h/%b/%h exp 8/0/0", bus.llc_op, bus.busy, bus.llc_addr);
        end
        checks++;
        if ({bus.stat_cpu, bus.stat_snp, bus.stat_hold} !== 48'd0) begin
            errors++; $display("FAIL rst_stats got %h exp 0", {bus.stat_cpu, bus.stat_snp, bus.stat_hold});
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.llc_op !== 4'd8 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_after got %h/%b exp 8/0", bus.llc_op, bus.busy);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_cpu = 0; exp_snp = 0; exp_hold = 0;
        test_reset();
        test_single_cpu();
        test_back_to_back();
        test_hold();
        test_streak();
        test_mnt_priority();
        test_illegal();
        test_stats();
        test_reset_in_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/llc_req_arbiter.md
Name: llc_req_arbiter

Overview:
- Front-end sequencer for the LLC model. Merges three request sources into the single op/addr stream the LLC consumes, one operation per cycle:
  - CPU/L1 requests: ops 0-2.
  - Snoop requests: ops 3-6.
  - Maintenance: ops 8-9.
- Honours the LLC hold indication, which extends an operation by one cycle.
- Replaces trace-driven direct driving of the LLC when multiple agents share it.

Parameters:
- IDLE_OP, 8: op code driven to the LLC when no operation is issued.
- MAX_SNP_STREAK, 4: consecutive snoop grants allowed while a CPU request waits.
- STAT_W, 16: width of the optional statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_valid  in  1  CPU request pending.
- cpu_op  in  4  CPU op code; legal values 0..2.
- cpu_addr  in  32  CPU address.
- cpu_ready  out  1  CPU request accepted this cycle.
- snp_valid  in  1  snoop request pending.
- snp_op  in  4  snoop op code; legal values 3..6.
- snp_addr  in  32  snoop address.
- snp_ready  out  1  snoop request accepted this cycle.
- mnt_valid  in  1  maintenance request pending.
- mnt_op  in  4  maintenance op code; legal values 8..9.
- mnt_ready  out  1  maintenance request accepted this cycle.
- llc_op  out  4  registered op to the LLC.
- llc_addr  out  32  registered address to the LLC.
- llc_hold  in  1  LLC needs one extra cycle for the current op.
- busy  out  1  state is not IDLE.
- illegal_op  out  1  one-cycle pulse when an out-of-range op is accepted and dropped.
- stat_cpu, stat_snp, stat_hold  out  STAT_W  optional counters.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values:
  - state = IDLE, llc_op = IDLE_OP, llc_addr = 0.
  - All readies 0, busy 0, illegal_op 0, streak counter 0, stats 0.
  - Reset asserted mid-operation aborts the op immediately; the request being held is lost.
- States:
  - IDLE: nothing on the LLC.
  - ISSUE: op driven, first cycle.
  - HOLD: op driven, extended cycle.
- Accept window (acc): state==IDLE, or (state==ISSUE && !llc_hold), or state==HOLD.
- Readies: combinational. Exactly one ready is high in a cycle where acc=1 and at least one valid is high. Otherwise all readies are 0.
- Priority:
  - mnt is highest.
  - snp beats cpu, except when streak==MAX_SNP_STREAK and cpu_valid=1; then cpu wins.
- Streak counter:
  - Increments on each snoop grant made while cpu_valid=1, saturating at MAX_SNP_STREAK.
  - Clears on any cpu grant.
  - Clears on any cycle where cpu_valid=0.
- Latency: request accepted in cycle N → llc_op/llc_addr hold its op/addr from cycle N+1, with state ISSUE.
- Transitions:
  - ISSUE & llc_hold=1 → HOLD. op/addr stay stable.
  - ISSUE & !llc_hold & new accept → ISSUE with the new op (back-to-back, 1 op/cycle).
  - ISSUE & !llc_hold & no accept → IDLE. llc_op = IDLE_OP, llc_addr unchanged.
  - HOLD → ISSUE if a request is accepted this cycle, else IDLE.
  - HOLD ignores llc_hold: exactly one extra cycle per op.
- Maintenance address: maintenance ops drive llc_addr = 0.
- Illegal ops:
  - Condition: op outside the source's legal range.
  - Response: request is accepted (ready=1) and dropped; illegal_op pulses in cycle N+1.
  - The op is not issued. State follows the no-accept path.
  - Stats and streak are not updated.
- Simultaneous valids: resolved purely by priority. Losers keep valid asserted, and their op/addr must stay stable until accepted.

Optional Feature:
- Macro: LLC_ARB_STATS_EN.
- When defined:
  - stat_cpu counts legal cpu grants; stat_snp counts legal snoop grants.
  - stat_hold counts cycles spent in HOLD.
  - All three are STAT_W-bit saturating counters, cleared by rst_n.
- When undefined: the stat ports exist but are tied to 0, and no counter flops are built.

Test Plan:
- Reset, then cpu_valid with op 0, addr 32'h1000_0040 in cycle 1 → cpu_ready=1 in cycle 1; llc_op=0, llc_addr=32'h1000_0040 in cycle 2; llc_op=8 in cycle 3.
- Two cpu ops back-to-back (op 1 @ 32'hA, op 2 @ 32'hB), llc_hold=0 → llc_op shows 1 then 2 on consecutive cycles, busy=1 for 2 cycles.
- Single op with llc_hold=1 in its first issue cycle → op/addr stable for 2 cycles, state goes ISSUE→HOLD→IDLE, stat_hold=1 (with LLC_ARB_STATS_EN).
- snp_valid and cpu_valid held high continuously, MAX_SNP_STREAK=4 → grant order snp,snp,snp,snp,cpu,snp…
- mnt_valid (op 9), snp_valid and cpu_valid in the same cycle → mnt_ready only; llc_op=9, llc_addr=0 next cycle.
- cpu_op=5 → cpu_ready=1, illegal_op=1 next cycle, llc_op stays 8. Then rst_n pulsed low during a HOLD → llc_op=8 and busy=0 immediately, without waiting for a clock edge.
